// File: rtl/adder_share_arb_if.sv
// adder_share_arb_if
//   Request/response channels between two requesters and the shared-adder arbiter.
//   slave  : arbiter side  (takes requests, returns results)
//   master : requester side (issues requests, consumes results)
//   req<N>_valid/ready/a/b/cin/sub : operation channel for requester N
//   rsp<N>_valid/ready/sum/cout    : result channel for requester N
interface adder_share_arb_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic             req0_sub;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
    logic             req1_sub;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_sum;
    logic             rsp0_cout;

    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_sum;
    logic             rsp1_cout;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_cin, req1_sub,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_sum, rsp0_cout,
        output rsp1_valid, rsp1_sum, rsp1_cout,
        input  rsp0_ready, rsp1_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin, req0_sub,
        output req1_valid, req1_a, req1_b, req1_cin, req1_sub,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_sum, rsp0_cout,
        input  rsp1_valid, rsp1_sum, rsp1_cout,
        output rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/adder_share_arb.sv
// adder_share_arb
//   Shares one external combinational (carry-lookahead) adder between two
//   requesters. Round-robin arbitration, registered operands held for LAT cycles
//   (multicycle path through the adder), result captured and returned on the
//   winner's response channel with a valid/ready handshake.
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : req0/req1 operation channels, rsp0/rsp1 result channels
//   add_a/add_b/add_cin : registered operands to the shared adder
//   add_sum/add_cout  : result from the shared adder
//   busy              : high whenever the FSM is not idle
//   rsp0_ovf/rsp1_ovf : signed overflow of the returned result (ADDARB_OVF_EN only)
// Build option
//   ADDARB_OVF_EN : adds the per-requester signed-overflow outputs.
//
// state  | meaning
// S_IDLE | waiting for a request, arbitration live, reqN_ready combinational
// S_BUSY | operands held on the adder, cnt counts down to the capture cycle
// S_RESP | result presented on the owner's response channel until taken
module adder_share_arb #(
    parameter int WIDTH = 16,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    adder_share_arb_if.slave bus,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
`ifdef ADDARB_OVF_EN
    output logic             rsp0_ovf,
    output logic             rsp1_ovf,
`endif
    output logic             busy
);

    if (LAT < 1 || LAT > 4) begin : g_lat_check
        $error("adder_share_arb: LAT must be in 1..4");
    end

    localparam int CW  = 2;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             add_cin_q, add_cin_d;
    logic [WIDTH-1:0] rsp0_sum_q, rsp0_sum_d;
    logic [WIDTH-1:0] rsp1_sum_q, rsp1_sum_d;
    logic             rsp0_cout_q, rsp0_cout_d;
    logic             rsp1_cout_q, rsp1_cout_d;
`ifdef ADDARB_OVF_EN
    logic             rsp0_ovf_q, rsp0_ovf_d;
    logic             rsp1_ovf_q, rsp1_ovf_d;
    logic             ovf_now;
`endif

    logic             grant0, grant1;
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_cin, op_sub;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        rsp0_sum_d  = rsp0_sum_q;
        rsp1_sum_d  = rsp1_sum_q;
        rsp0_cout_d = rsp0_cout_q;
        rsp1_cout_d = rsp1_cout_q;
`ifdef ADDARB_OVF_EN
        rsp0_ovf_d  = rsp0_ovf_q;
        rsp1_ovf_d  = rsp1_ovf_q;
        ovf_now     = (add_a_q[MSB] == add_b_q[MSB]) && (add_sum[MSB] != add_a_q[MSB]);
`endif
        grant0      = 1'b0;
        grant1      = 1'b0;
        op_a        = bus.req0_a;
        op_b        = bus.req0_b;
        op_cin      = bus.req0_cin;
        op_sub      = bus.req0_sub;

        case (state_q)
            S_IDLE: begin
                // On a tie the port that did not win last time gets the grant.
                grant0 = bus.req0_valid && (!bus.req1_valid || last_q);
                grant1 = bus.req1_valid && !grant0;
                if (grant1) begin
                    op_a   = bus.req1_a;
                    op_b   = bus.req1_b;
                    op_cin = bus.req1_cin;
                    op_sub = bus.req1_sub;
                end
                if (grant0 || grant1) begin
                    // Subtraction as A + ~B + 1; carry out then means "no borrow".
                    add_a_d   = op_a;
                    add_b_d   = op_sub ? ~op_b : op_b;
                    add_cin_d = op_sub ? 1'b1 : op_cin;
                    owner_d   = grant1;
                    last_d    = grant1;
                    cnt_d     = CW'(LAT - 1);
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    if (owner_q) begin
                        rsp1_sum_d  = add_sum;
                        rsp1_cout_d = add_cout;
`ifdef ADDARB_OVF_EN
                        rsp1_ovf_d  = ovf_now;
`endif
                    end else begin
                        rsp0_sum_d  = add_sum;
                        rsp0_cout_d = add_cout;
`ifdef ADDARB_OVF_EN
                        rsp0_ovf_d  = ovf_now;
`endif
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            rsp0_sum_q  <= '0;
            rsp1_sum_q  <= '0;
            rsp0_cout_q <= 1'b0;
            rsp1_cout_q <= 1'b0;
`ifdef ADDARB_OVF_EN
            rsp0_ovf_q  <= 1'b0;
            rsp1_ovf_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            rsp0_sum_q  <= rsp0_sum_d;
            rsp1_sum_q  <= rsp1_sum_d;
            rsp0_cout_q <= rsp0_cout_d;
            rsp1_cout_q <= rsp1_cout_d;
`ifdef ADDARB_OVF_EN
            rsp0_ovf_q  <= rsp0_ovf_d;
            rsp1_ovf_q  <= rsp1_ovf_d;
`endif
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = (state_q == S_RESP) && !owner_q;
    assign bus.rsp1_valid = (state_q == S_RESP) && owner_q;
    assign bus.rsp0_sum   = rsp0_sum_q;
    assign bus.rsp1_sum   = rsp1_sum_q;
    assign bus.rsp0_cout  = rsp0_cout_q;
    assign bus.rsp1_cout  = rsp1_cout_q;
`ifdef ADDARB_OVF_EN
    assign rsp0_ovf       = rsp0_ovf_q;
    assign rsp1_ovf       = rsp1_ovf_q;
`endif
    assign add_a          = add_a_q;
    assign add_b          = add_b_q;
    assign add_cin        = add_cin_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_adder_share_arb.sv
module tb_adder_share_arb;
    localparam int WIDTH = 16;
    localparam int LAT   = 2;

    logic        clk;
    logic        rst;
    logic [15:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout, busy;
`ifdef ADDARB_OVF_EN
    logic        rsp0_ovf, rsp1_ovf;
`endif
    int          cyc;
    int          errors;
    int          checks;

    adder_share_arb_if #(.WIDTH(WIDTH)) bus ();

    adder_share_arb #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
`ifdef ADDARB_OVF_EN
        .rsp0_ovf (rsp0_ovf),
        .rsp1_ovf (rsp1_ovf),
`endif
        .busy     (busy)
    );

    // The shared combinational adder itself.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the requested operation.
    function automatic logic [16:0] model_sum(input logic [15:0] a, input logic [15:0] b,
                                              input logic cin, input logic sub);
        int r;
        if (sub) begin
            r = int'(a) - int'(b);
            return {(r >= 0), r[15:0]};
        end
        r = int'(a) + int'(b) + int'(cin);
        return r[16:0];
    endfunction

    function automatic logic model_ovf(input logic [15:0] a, input logic [15:0] b,
                                       input logic cin, input logic sub);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sub ? sa - sb : sa + sb + int'(cin);
        return (r > 32767) || (r < -32768);
    endfunction

    task automatic set_req(input int port, input logic v, input logic [15:0] a,
                           input logic [15:0] b, input logic cin, input logic sub);
        if (port == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
            bus.req0_cin = cin; bus.req0_sub = sub;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
            bus.req1_cin = cin; bus.req1_sub = sub;
        end
    endtask

    function automatic logic req_ready(input int port);
        return (port == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    function automatic logic rsp_valid(input int port);
        return (port == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction

    // One complete operation on a port with rsp ready held high.
    task automatic run_op(input int port, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] es,
                          input logic ec, input logic eo);
        int t_acc, t_rsp;
        bit ok;
        t_acc = 0;
        t_rsp = 0;
        @(negedge clk);
        set_req(port, 1'b1, a, b, cin, sub);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready(port)) begin ok = 1; t_acc = cyc; break; end
            @(negedge clk);
        end
        chk("accept", 32'(ok), 32'd1);
        @(negedge clk);
        set_req(port, 1'b0, a, b, cin, sub);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rsp_valid(port)) begin ok = 1; t_rsp = cyc; break; end
            @(negedge clk);
        end
        chk("rsp_seen", 32'(ok), 32'd1);
        chk("latency", 32'(t_rsp - t_acc), 32'(LAT + 1));
        chk("other_rsp_valid", 32'(rsp_valid(1 - port)), 32'd0);
        chk("sum", 32'((port == 0) ? bus.rsp0_sum : bus.rsp1_sum), 32'(es));
        chk("cout", 32'((port == 0) ? bus.rsp0_cout : bus.rsp1_cout), 32'(ec));
`ifdef ADDARB_OVF_EN
        chk("ovf", 32'((port == 0) ? rsp0_ovf : rsp1_ovf), 32'(eo));
`else
        if (eo === 1'bx) chk("ovf_arg", 32'(eo), 32'd0);
`endif
    endtask

    initial begin
        int          order[4];
        int          tacc[4];
        int          n_acc, n_rsp;
        bit          ok;
        logic [15:0] ra, rb;
        logic        rcin, rsub;
        logic [16:0] rexp;
        int          rport;

        errors = 0;
        checks = 0;
        cyc    = 0;
        rst    = 1'b1;
        set_req(0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        set_req(1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;

        vecs[0] = '{0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{1, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{1, 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[3] = '{0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{0, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[5] = '{1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[6] = '{0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{1, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
        chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        chk("rst_rsp0_sum", 32'(bus.rsp0_sum), 32'd0);
        chk("rst_rsp1_sum", 32'(bus.rsp1_sum), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_add_cin", 32'(add_cin), 32'd0);

        // Round-robin with both requesters continuously valid.
        @(negedge clk);
        set_req(0, 1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
        set_req(1, 1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0);
        n_acc = 0;
        n_rsp = 0;
        for (int i = 0; i < 60 && n_acc < 4; i++) begin
            #1;
            chk("rr_excl", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            if (bus.req0_ready || bus.req1_ready) begin
                order[n_acc] = bus.req1_ready ? 1 : 0;
                tacc[n_acc]  = cyc;
                n_acc++;
            end
            if (bus.rsp0_valid) begin chk("rr_sum0", 32'(bus.rsp0_sum), 32'h3); n_rsp++; end
            if (bus.rsp1_valid) begin chk("rr_sum1", 32'(bus.rsp1_sum), 32'h7); n_rsp++; end
            @(negedge clk);
        end
        set_req(0, 1'b0, 16'h0001, 16'h0002, 1'b0, 1'b0);
        set_req(1, 1'b0, 16'h0003, 16'h0004, 1'b0, 1'b0);
        for (int i = 0; i < LAT + 4; i++) begin
            #1;
            if (bus.rsp0_valid) begin chk("rr_sum0", 32'(bus.rsp0_sum), 32'h3); n_rsp++; end
            if (bus.rsp1_valid) begin chk("rr_sum1", 32'(bus.rsp1_sum), 32'h7); n_rsp++; end
            @(negedge clk);
        end
        chk("rr_accepts", 32'(n_acc), 32'd4);
        chk("rr_responses", 32'(n_rsp), 32'd4);
        for (int i = 0; i < n_acc; i++) begin
            chk("rr_order", 32'(order[i]), 32'(i % 2));
            if (i > 0) chk("rr_spacing", 32'(tacc[i] - tacc[i-1]), 32'(LAT + 2));
        end

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   vecs[i].es, vecs[i].ec, vecs[i].eo);
        end

        // Backpressure on rsp0 while req1 waits.
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
        set_req(0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req0_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("bp_accept0", 32'(ok), 32'd1);
        @(negedge clk);
        set_req(0, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0);
        set_req(1, 1'b1, 16'h0100, 16'h0001, 1'b0, 1'b0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.rsp0_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("bp_rsp0_seen", 32'(ok), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus.rsp0_valid), 32'd1);
            chk("bp_sum", 32'(bus.rsp0_sum), 32'h3333);
            chk("bp_cout", 32'(bus.rsp0_cout), 32'd0);
            chk("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            @(negedge clk);
            #1;
        end
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_idle_busy", 32'(busy), 32'd0);
        chk("bp_rsp0_gone", 32'(bus.rsp0_valid), 32'd0);
        chk("bp_req1_ready", 32'(bus.req1_ready), 32'd1);
        @(negedge clk);
        set_req(1, 1'b0, 16'h0100, 16'h0001, 1'b0, 1'b0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.rsp1_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("bp_rsp1_seen", 32'(ok), 32'd1);
        chk("bp_rsp1_sum", 32'(bus.rsp1_sum), 32'h0101);

        // Reset while BUSY with one count remaining.
        @(negedge clk);
        set_req(0, 1'b1, 16'h00AA, 16'h0055, 1'b0, 1'b0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req0_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("rb_accept", 32'(ok), 32'd1);
        @(negedge clk);
        set_req(0, 1'b0, 16'h00AA, 16'h0055, 1'b0, 1'b0);
        #1;
        chk("rb_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rb_busy", 32'(busy), 32'd0);
        chk("rb_req0_ready", 32'(bus.req0_ready), 32'd0);
        chk("rb_req1_ready", 32'(bus.req1_ready), 32'd0);
        chk("rb_rsp0_sum", 32'(bus.rsp0_sum), 32'd0);
        for (int i = 0; i < LAT + 3; i++) begin
            chk("rb_no_rsp", 32'(bus.rsp0_valid | bus.rsp1_valid), 32'd0);
            @(negedge clk);
            #1;
        end
        set_req(0, 1'b1, 16'h0010, 16'h0020, 1'b0, 1'b0);
        set_req(1, 1'b1, 16'h0030, 16'h0040, 1'b0, 1'b0);
        #1;
        chk("rb_tie_req0", 32'(bus.req0_ready), 32'd1);
        chk("rb_tie_req1", 32'(bus.req1_ready), 32'd0);
        @(negedge clk);
        set_req(0, 1'b0, 16'h0010, 16'h0020, 1'b0, 1'b0);
        set_req(1, 1'b0, 16'h0030, 16'h0040, 1'b0, 1'b0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.rsp0_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("rb_rsp0_seen", 32'(ok), 32'd1);
        chk("rb_rsp0_sum", 32'(bus.rsp0_sum), 32'h0030);

        // Randomized operations against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            rport = int'($urandom_range(0, 1));
            ra    = 16'($urandom);
            rb    = 16'($urandom);
            rcin  = 1'($urandom);
            rsub  = 1'($urandom);
            rexp  = model_sum(ra, rb, rcin, rsub);
            run_op(rport, ra, rb, rcin, rsub, rexp[15:0], rexp[16],
                   model_ovf(ra, rb, rcin, rsub));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
